// File: rtl/irq_ctrl.sv
// Edge-triggered interrupt controller: pending latch, enable masking, fixed priority, trap PC.
// Define IRQ_CTRL_NESTING_EN to allow one level of higher-priority preemption during a handler.
module irq_ctrl #(
    parameter int unsigned NUM_IRQ = 8,
    parameter int unsigned ID_W    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic               global_ie,
    input  logic [31:0]        mtvec,
    input  logic               interrupt_taken,
    input  logic               mret_taken,
    output logic               interrupt_req,
    output logic [ID_W-1:0]    irq_id,
    output logic [31:0]        trap_pc,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic               in_service,
    output logic [NUM_IRQ-1:0] pending
);

`ifdef IRQ_CTRL_NESTING_EN
    typedef enum logic [2:0] {StIdle, StReq, StSvc, StReqN, StSvcN} state_e;
    logic [ID_W-1:0] save_q, save_d;
`else
    typedef enum logic [2:0] {StIdle, StReq, StSvc} state_e;
`endif

    state_e state_q, state_d;

    logic [NUM_IRQ-1:0] src_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] irq_edge, eligible;
    logic [ID_W-1:0]    id_q, id_d, winner;
    logic               any_eligible;
    logic               unused_mtvec_lsb;

    assign unused_mtvec_lsb = ^mtvec[1:0];

    assign irq_edge  = irq_src & ~src_q;
    assign eligible  = pending_q & irq_en & {NUM_IRQ{global_ie}};
    // A new edge on a bit being acknowledged keeps it pending.
    assign pending_d = (pending_q & ~irq_ack) | irq_edge;

    always_comb begin
        winner       = '0;
        any_eligible = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (eligible[i] && !any_eligible) begin
                winner       = ID_W'(i);
                any_eligible = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
`ifdef IRQ_CTRL_NESTING_EN
        save_d  = save_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (any_eligible) begin
                    id_d    = winner;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (interrupt_taken) state_d = StSvc;
            end
            StSvc: begin
                if (mret_taken) begin
                    state_d = StIdle;
`ifdef IRQ_CTRL_NESTING_EN
                end else if (any_eligible && (winner < id_q)) begin
                    save_d  = id_q;
                    id_d    = winner;
                    state_d = StReqN;
`endif
                end
            end
`ifdef IRQ_CTRL_NESTING_EN
            StReqN: begin
                if (interrupt_taken) state_d = StSvcN;
            end
            StSvcN: begin
                if (mret_taken) begin
                    id_d    = save_q;
                    state_d = StSvc;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        interrupt_req = 1'b0;
        in_service    = 1'b0;
        irq_ack       = '0;
        unique case (state_q)
            StReq: begin
                interrupt_req = 1'b1;
                if (interrupt_taken) irq_ack = NUM_IRQ'(1) << id_q;
            end
            StSvc: in_service = 1'b1;
`ifdef IRQ_CTRL_NESTING_EN
            StReqN: begin
                interrupt_req = 1'b1;
                in_service    = 1'b1;
                if (interrupt_taken) irq_ack = NUM_IRQ'(1) << id_q;
            end
            StSvcN: in_service = 1'b1;
`endif
            default: ;
        endcase
    end

    // src_q keeps tracking the lines through reset so a level held across reset is not a new event.
    always_ff @(posedge clk) begin
        src_q <= irq_src;
        if (rst) begin
            pending_q <= '0;
            id_q      <= '0;
`ifdef IRQ_CTRL_NESTING_EN
            save_q    <= '0;
`endif
        end else begin
            pending_q <= pending_d;
            id_q      <= id_d;
`ifdef IRQ_CTRL_NESTING_EN
            save_q    <= save_d;
`endif
        end
    end

    assign irq_id  = id_q;
    assign pending = pending_q;
    assign trap_pc = {mtvec[31:2], 2'b00} + {{(30 - ID_W){1'b0}}, id_q, 2'b00};

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed vector table plus hand-written nesting/reset sequences.
module tb_irq_ctrl;

    logic        clk;
    logic        rst;
    logic [7:0]  irq_src;
    logic [7:0]  irq_en;
    logic        global_ie;
    logic [31:0] mtvec;
    logic        interrupt_taken;
    logic        mret_taken;
    logic        interrupt_req;
    logic [2:0]  irq_id;
    logic [31:0] trap_pc;
    logic [7:0]  irq_ack;
    logic        in_service;
    logic [7:0]  pending;

    int checks = 0;
    int errors = 0;

    irq_ctrl #(
        .NUM_IRQ(8),
        .ID_W   (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .irq_src        (irq_src),
        .irq_en         (irq_en),
        .global_ie      (global_ie),
        .mtvec          (mtvec),
        .interrupt_taken(interrupt_taken),
        .mret_taken     (mret_taken),
        .interrupt_req  (interrupt_req),
        .irq_id         (irq_id),
        .trap_pc        (trap_pc),
        .irq_ack        (irq_ack),
        .in_service     (in_service),
        .pending        (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] src;
        logic [7:0] en;
        logic       ie;
        logic       tk;
        logic       mr;
        logic       req;
        logic [2:0] id;
        logic [7:0] ack;
        logic       svc;
        logic [7:0] pend;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [7:0] s, input logic [7:0] en, input logic ie, input logic tk,
                       input logic mr, input logic req, input logic [2:0] id, input logic [7:0] ack,
                       input logic svc, input logic [7:0] pend);
        vec_t v;
        v = '{s, en, ie, tk, mr, req, id, ack, svc, pend};
        vq.push_back(v);
    endtask

    // Drive one cycle of inputs, compare outputs on the falling edge, then advance past posedge.
    task automatic step(input string name, input logic [7:0] s, input logic [7:0] en,
                        input logic ie, input logic tk, input logic mr, input logic req_e,
                        input logic [2:0] id_e, input logic [7:0] ack_e, input logic svc_e,
                        input logic [7:0] pend_e);
        logic [31:0] pc_e;
        irq_src         = s;
        irq_en          = en;
        global_ie       = ie;
        interrupt_taken = tk;
        mret_taken      = mr;
        @(negedge clk);
        pc_e = {mtvec[31:2], 2'b00} + 32'(id_e) * 32'd4;
        checks++;
        if (interrupt_req !== req_e || irq_id !== id_e || irq_ack !== ack_e ||
            in_service !== svc_e || pending !== pend_e || trap_pc !== pc_e) begin
            errors++;
            $display("FAIL %s: got req=%0b id=%0d ack=%h svc=%0b pend=%h pc=%h, want req=%0b id=%0d ack=%h svc=%0b pend=%h pc=%h",
                     name, interrupt_req, irq_id, irq_ack, in_service, pending, trap_pc,
                     req_e, id_e, ack_e, svc_e, pend_e, pc_e);
        end
        @(posedge clk);
        #1;
    endtask

    logic [2:0] lid;

    initial begin
        rst             = 1'b1;
        irq_src         = '0;
        irq_en          = 8'hFF;
        global_ie       = 1'b1;
        mtvec           = 32'h0000_0100;
        interrupt_taken = 1'b0;
        mret_taken      = 1'b0;
        @(posedge clk);
        #1;
        step("reset", 8'h00, 8'hFF, 1, 0, 0, 0, 0, 8'h00, 0, 8'h00);
        rst = 1'b0;

        // Single source, latency, ack, service, mret
        add(8'h00, 8'hFF, 1, 0, 0, 0, 0, 8'h00, 0, 8'h00);
        add(8'h08, 8'hFF, 1, 0, 0, 0, 0, 8'h00, 0, 8'h00);
        add(8'h08, 8'hFF, 1, 0, 0, 0, 0, 8'h00, 0, 8'h08);
        add(8'h08, 8'hFF, 1, 0, 0, 1, 3, 8'h00, 0, 8'h08);
        add(8'h08, 8'hFF, 1, 1, 0, 1, 3, 8'h08, 0, 8'h08);
        add(8'h08, 8'hFF, 1, 0, 0, 0, 3, 8'h00, 1, 8'h00);
        add(8'h08, 8'hFF, 1, 0, 1, 0, 3, 8'h00, 1, 8'h00);
        add(8'h00, 8'hFF, 1, 0, 0, 0, 3, 8'h00, 0, 8'h00);
        // Simultaneous 5 and 2: 2 first, then 5
        add(8'h24, 8'hFF, 1, 0, 0, 0, 3, 8'h00, 0, 8'h00);
        add(8'h24, 8'hFF, 1, 0, 0, 0, 3, 8'h00, 0, 8'h24);
        add(8'h24, 8'hFF, 1, 0, 0, 1, 2, 8'h00, 0, 8'h24);
        add(8'h24, 8'hFF, 1, 1, 0, 1, 2, 8'h04, 0, 8'h24);
        add(8'h24, 8'hFF, 1, 0, 0, 0, 2, 8'h00, 1, 8'h20);
        add(8'h24, 8'hFF, 1, 0, 1, 0, 2, 8'h00, 1, 8'h20);
        add(8'h24, 8'hFF, 1, 0, 0, 0, 2, 8'h00, 0, 8'h20);
        add(8'h24, 8'hFF, 1, 0, 0, 1, 5, 8'h00, 0, 8'h20);
        add(8'h24, 8'hFF, 1, 1, 0, 1, 5, 8'h20, 0, 8'h20);
        add(8'h24, 8'hFF, 1, 0, 1, 0, 5, 8'h00, 1, 8'h00);
        add(8'h00, 8'hFF, 1, 0, 0, 0, 5, 8'h00, 0, 8'h00);
        // Masked pending, then enabled; request survives mask/ie drop
        add(8'h10, 8'hEF, 1, 0, 0, 0, 5, 8'h00, 0, 8'h00);
        add(8'h10, 8'hEF, 1, 0, 0, 0, 5, 8'h00, 0, 8'h10);
        add(8'h10, 8'hEF, 1, 0, 0, 0, 5, 8'h00, 0, 8'h10);
        add(8'h10, 8'hFF, 1, 0, 0, 0, 5, 8'h00, 0, 8'h10);
        add(8'h10, 8'h00, 0, 0, 0, 1, 4, 8'h00, 0, 8'h10);
        add(8'h10, 8'h00, 0, 1, 0, 1, 4, 8'h10, 0, 8'h10);
        add(8'h10, 8'hFF, 1, 0, 1, 0, 4, 8'h00, 1, 8'h00);
        add(8'h00, 8'hFF, 1, 0, 0, 0, 4, 8'h00, 0, 8'h00);
        // New edge in the acceptance cycle keeps pending set
        add(8'h08, 8'hFF, 1, 0, 0, 0, 4, 8'h00, 0, 8'h00);
        add(8'h00, 8'hFF, 1, 0, 0, 0, 4, 8'h00, 0, 8'h08);
        add(8'h00, 8'hFF, 1, 0, 0, 1, 3, 8'h00, 0, 8'h08);
        add(8'h08, 8'hFF, 1, 1, 0, 1, 3, 8'h08, 0, 8'h08);
        add(8'h08, 8'hFF, 1, 0, 0, 0, 3, 8'h00, 1, 8'h08);
        add(8'h08, 8'hFF, 1, 0, 1, 0, 3, 8'h00, 1, 8'h08);
        add(8'h08, 8'hFF, 1, 0, 0, 0, 3, 8'h00, 0, 8'h08);
        add(8'h08, 8'hFF, 1, 0, 0, 1, 3, 8'h00, 0, 8'h08);
        add(8'h08, 8'hFF, 1, 1, 0, 1, 3, 8'h08, 0, 8'h08);
        add(8'h08, 8'hFF, 1, 0, 1, 0, 3, 8'h00, 1, 8'h00);
        add(8'h00, 8'hFF, 1, 0, 0, 0, 3, 8'h00, 0, 8'h00);
        // global_ie gating; taken/mret ignored outside their states
        add(8'h02, 8'hFF, 0, 0, 0, 0, 3, 8'h00, 0, 8'h00);
        add(8'h02, 8'hFF, 0, 0, 0, 0, 3, 8'h00, 0, 8'h02);
        add(8'h02, 8'hFF, 0, 1, 1, 0, 3, 8'h00, 0, 8'h02);
        add(8'h00, 8'hFF, 1, 0, 0, 0, 3, 8'h00, 0, 8'h02);
        add(8'h00, 8'hFF, 1, 0, 1, 1, 1, 8'h00, 0, 8'h02);
        add(8'h00, 8'hFF, 1, 1, 0, 1, 1, 8'h02, 0, 8'h02);
        add(8'h00, 8'hFF, 1, 0, 1, 0, 1, 8'h00, 1, 8'h00);
        add(8'h00, 8'hFF, 1, 0, 0, 0, 1, 8'h00, 0, 8'h00);

        foreach (vq[i]) begin
            step($sformatf("vec%0d", i), vq[i].src, vq[i].en, vq[i].ie, vq[i].tk, vq[i].mr,
                 vq[i].req, vq[i].id, vq[i].ack, vq[i].svc, vq[i].pend);
        end

        // Higher-priority source arriving while id 6 is in service
        step("n_idle",  8'h40, 8'hFF, 1, 0, 0, 0, 1, 8'h00, 0, 8'h00);
        step("n_pend",  8'h40, 8'hFF, 1, 0, 0, 0, 1, 8'h00, 0, 8'h40);
        step("n_req6",  8'h40, 8'hFF, 1, 0, 0, 1, 6, 8'h00, 0, 8'h40);
        step("n_ack6",  8'h40, 8'hFF, 1, 1, 0, 1, 6, 8'h40, 0, 8'h40);
        step("n_svc6",  8'h42, 8'hFF, 1, 0, 0, 0, 6, 8'h00, 1, 8'h00);
        step("n_pend1", 8'h42, 8'hFF, 1, 0, 0, 0, 6, 8'h00, 1, 8'h02);
`ifdef IRQ_CTRL_NESTING_EN
        step("n_reqn1", 8'h42, 8'hFF, 1, 1, 0, 1, 1, 8'h02, 1, 8'h02);
        step("n_svcn1", 8'h42, 8'hFF, 1, 0, 0, 0, 1, 8'h00, 1, 8'h00);
        step("n_mretn", 8'h42, 8'hFF, 1, 0, 1, 0, 1, 8'h00, 1, 8'h00);
        step("n_pop6",  8'h42, 8'hFF, 1, 0, 0, 0, 6, 8'h00, 1, 8'h00);
        step("n_mret",  8'h42, 8'hFF, 1, 0, 1, 0, 6, 8'h00, 1, 8'h00);
        step("n_done",  8'h00, 8'hFF, 1, 0, 0, 0, 6, 8'h00, 0, 8'h00);
        lid = 3'd6;
`else
        step("n_hold",  8'h42, 8'hFF, 1, 0, 0, 0, 6, 8'h00, 1, 8'h02);
        step("n_mret6", 8'h42, 8'hFF, 1, 0, 1, 0, 6, 8'h00, 1, 8'h02);
        step("n_idle2", 8'h42, 8'hFF, 1, 0, 0, 0, 6, 8'h00, 0, 8'h02);
        step("n_req1",  8'h42, 8'hFF, 1, 1, 0, 1, 1, 8'h02, 0, 8'h02);
        step("n_mret1", 8'h42, 8'hFF, 1, 0, 1, 0, 1, 8'h00, 1, 8'h00);
        step("n_done",  8'h00, 8'hFF, 1, 0, 0, 0, 1, 8'h00, 0, 8'h00);
        lid = 3'd1;
`endif

        // Reset while in service with pending 0x81; held lines must not re-trigger
        step("r_edge",  8'h04, 8'hFF, 1, 0, 0, 0, lid, 8'h00, 0, 8'h00);
        step("r_pend",  8'h04, 8'hFF, 1, 0, 0, 0, lid, 8'h00, 0, 8'h04);
        step("r_req2",  8'h04, 8'hFF, 1, 0, 0, 1, 2, 8'h00, 0, 8'h04);
        step("r_ack2",  8'h04, 8'hFF, 1, 1, 0, 1, 2, 8'h04, 0, 8'h04);
        step("r_svc2",  8'h85, 8'hFF, 1, 0, 0, 0, 2, 8'h00, 1, 8'h00);
        rst = 1'b1;
        step("r_p81",   8'h85, 8'hFF, 1, 0, 0, 0, 2, 8'h00, 1, 8'h81);
        rst = 1'b0;
        step("r_clr0",  8'h85, 8'hFF, 1, 0, 0, 0, 0, 8'h00, 0, 8'h00);
        step("r_clr1",  8'h85, 8'hFF, 1, 0, 0, 0, 0, 8'h00, 0, 8'h00);
        step("r_clr2",  8'h85, 8'hFF, 1, 0, 0, 0, 0, 8'h00, 0, 8'h00);
        mtvec = 32'h0000_0203;
        step("r_mtvec", 8'h00, 8'hFF, 1, 0, 0, 0, 0, 8'h00, 0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
